v2f_seq_mul: RTL

V2F_SEQ_MUL -- requirements
Module: v2f_seq_mul

---
 rtl/v2f_seq_mul.sv | 116 +++++++++++
 1 files changed

// File: rtl/v2f_seq_mul.sv
// Sequential multiplier built from 16x16 limb products, one per cycle.
// Signed operands are multiplied as magnitudes and the sign is applied once at the end.
module v2f_seq_mul #(
  parameter  int WIDTH  = 32,
  parameter  int FULL   = 0,
  parameter  int SIGNED = 0,
  localparam int YW     = (FULL != 0) ? 2 * WIDTH : WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [YW-1:0]    y
);

  localparam int         L   = WIDTH / 16;
  localparam logic [1:0] LM1 = 2'(L - 1);

  if (!(WIDTH == 16 || WIDTH == 32 || WIDTH == 48 || WIDTH == 64)) begin : g_bad_width
    $error("v2f_seq_mul: WIDTH must be 16, 32, 48 or 64");
  end

  typedef enum logic [1:0] {IDLE, MUL, SIGN} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_mag, b_mag, a_abs, b_abs;
  logic               sign;
  logic [2*WIDTH-1:0] acc, pp_ext;
  logic [1:0]         i_idx, j_idx, j_last;
  logic [2:0]         limb_sum;
  logic [15:0]        a_limb, b_limb;
  logic [31:0]        pp;
  logic               last_pair;
  logic [YW-1:0]      res;

  assign a_abs = (SIGNED != 0 && a[WIDTH-1]) ? -a : a;
  assign b_abs = (SIGNED != 0 && b[WIDTH-1]) ? -b : b;

  // Truncated mode only visits pairs whose product lands below bit WIDTH.
  always_comb begin
    a_limb    = a_mag[16*i_idx +: 16];
    b_limb    = b_mag[16*j_idx +: 16];
    pp        = {16'b0, a_limb} * {16'b0, b_limb};
    limb_sum  = {1'b0, i_idx} + {1'b0, j_idx};
    pp_ext    = '0;
    pp_ext[31:0] = pp;
    pp_ext    = pp_ext << {limb_sum, 4'b0000};
    j_last    = (FULL != 0) ? LM1 : LM1 - i_idx;
    last_pair = (i_idx == LM1) && (j_idx == j_last);
    res       = (SIGNED != 0 && sign) ? YW'(-acc) : YW'(acc);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL;
      MUL:     if (last_pair) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == SIGN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      a_mag <= '0;
      b_mag <= '0;
      sign  <= 1'b0;
      i_idx <= '0;
      j_idx <= '0;
      y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            a_mag <= a_abs;
            b_mag <= b_abs;
            sign  <= (SIGNED != 0) && (a[WIDTH-1] ^ b[WIDTH-1]);
            i_idx <= '0;
            j_idx <= '0;
          end
        end
        MUL: begin
          acc <= acc + pp_ext;
          if (j_idx == j_last) begin
            j_idx <= '0;
            i_idx <= i_idx + 2'd1;
          end else begin
            j_idx <= j_idx + 2'd1;
          end
        end
        SIGN:    y <= res;
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == MUL) || (state == SIGN);

endmodule
